blink_rate_select: RTL
======================

# blink_rate_select

Downstream consumer of the four free-running LED blink generators (10/5/2/1 Hz toggles). Takes their four square waves plus one push-button, debounces the button, and on each debounced press steps a selector through 10 Hz → 5 Hz → 2 Hz → 1 Hz → OFF → 10 Hz. The selected blink drives a single registered LED output.

## Interface
- g_DEBOUNCE_LIMIT, 250000, consecutive synchronized cycles the switch must differ from its debounced level before the level is accepted (10 ms at 25 MHz); legal range 1..2^32-1.
- i_Clk  input  1  system clock; all flops on rising edge.
- i_Rst_L  input  1  reset, asynchronous assert, active-low; one clock; all state cleared while low.
- i_Switch_1  input  1  raw push-button, asynchronous, bouncy, 1 = pressed.
- i_Blink  input  4  blink generator outputs, bit0 = 10 Hz, bit1 = 5 Hz, bit2 = 2 Hz, bit3 = 1 Hz; synchronous to i_Clk.
- o_LED  output  1  selected blink, registered.
- o_Sel  output  3  current selection: 0 = 10 Hz, 1 = 5 Hz, 2 = 2 Hz, 3 = 1 Hz, 4 = OFF; values 5-7 never produced.
- o_Switch_Db  output  1  debounced switch level (visibility/test).

## Operation
- Synchronizer: two flops on i_Switch_1 → r_Sync. No logic on the first flop.
- Debouncer: 32-bit counter r_Cnt, debounced level r_Db (= o_Switch_Db).
  - r_Sync == r_Db: r_Cnt <= 0.
  - r_Sync != r_Db and r_Cnt == g_DEBOUNCE_LIMIT-1: r_Db <= r_Sync, r_Cnt <= 0.
  - r_Sync != r_Db otherwise: r_Cnt <= r_Cnt + 1.
  - Any single cycle of agreement restarts the count; counter never wraps.
- Press event: the cycle in which r_Db is updated 0 → 1. Release (1 → 0) causes no action.
- Selector FSM, states S_10HZ(0), S_5HZ(1), S_2HZ(2), S_1HZ(3), S_OFF(4). On a press event: 0→1→2→3→4→0. Advance occurs on the same edge r_Db goes high. Otherwise hold.
- LED: in states 0-3, o_LED <= i_Blink[o_Sel]; in S_OFF, o_LED <= 0. Uses the registered o_Sel value, so a selection change takes effect on o_LED one edge later.
- Reset values: sync flops 0, r_Cnt 0, o_Switch_Db 0, o_Sel 0 (S_10HZ), o_LED 0. A switch held high through reset release is treated as a new press after debounce. Reset mid-debounce discards the partial count.

## Timing
- With i_Switch_1 rising before edge 1 and held, r_Sync is high after edge 2. o_Switch_Db and o_Sel update at edge g_DEBOUNCE_LIMIT+2. o_LED reflects the new selection at edge g_DEBOUNCE_LIMIT+3.
- i_Blink → o_LED latency: exactly 1 cycle in states 0-3.
- A pulse on r_Sync shorter than g_DEBOUNCE_LIMIT cycles produces no change on o_Switch_Db or o_Sel.
- At most one FSM advance per press. Minimum press-to-press spacing is 2×g_DEBOUNCE_LIMIT synchronized cycles (press plus release debounce).

## Test plan
- Reset: hold i_Rst_L=0 with i_Switch_1=1 and i_Blink=4'hF → o_LED=0, o_Sel=0, o_Switch_Db=0 asynchronously; no change while reset is held.
- Debounce latency (LIMIT=4): raise switch before edge 1 and hold → o_Switch_Db and o_Sel=1 at edge 6; o_LED tracks i_Blink[1] from edge 7.
- Glitch rejection (LIMIT=4): switch pulses of 1, 2 and 3 synchronized cycles, plus a 3-high/1-low/3-high bounce → o_Sel stays 0 and o_Switch_Db stays 0.
- Full cycle (LIMIT=4): five clean press/release pairs → o_Sel 1,2,3,4,0. In state 4, o_LED=0 with i_Blink=4'hF. In each state 0-3, toggle only the selected bit and check o_LED follows it one cycle later while the other bits are ignored.
- Release no-op: hold the switch high 100 cycles, then release and debounce → o_Switch_Db returns to 0 and o_Sel is unchanged.
- Reset mid-operation: assert i_Rst_L while in state 3 with r_Cnt=2 → immediate o_Sel=0, o_LED=0. After release, a held-high switch produces one advance to o_Sel=1 after the full debounce time.

Source files
------------

// File: rtl/blink_rate_select.sv
// -----------------------------------------------------------------------------
// blink_rate_select
//
// Picks one of four free-running blink square waves and drives it onto a single
// registered LED output. A push-button is synchronized and debounced. Each
// debounced press (a 0 -> 1 change of the debounced level) steps the selection
// 10 Hz -> 5 Hz -> 2 Hz -> 1 Hz -> OFF -> 10 Hz. Release has no effect.
//
// Parameters
//   g_DEBOUNCE_LIMIT : consecutive synchronized cycles the switch must differ
//                      from its debounced level before the new level is
//                      accepted (1 .. 2^32-1).
//
// Ports
//   i_Clk        in   1  system clock, rising edge
//   i_Rst_L      in   1  asynchronous assert, active-low reset
//   i_Switch_1   in   1  raw push-button, asynchronous and bouncy, 1 = pressed
//   i_Blink      in   4  blink inputs: bit0 10 Hz, bit1 5 Hz, bit2 2 Hz, bit3 1 Hz
//   o_LED        out  1  selected blink, registered
//   o_Sel        out  3  selector state (0 10 Hz, 1 5 Hz, 2 2 Hz, 3 1 Hz, 4 OFF);
//                        this is the FSM state register itself, so checkers can
//                        bind to it directly
//   o_Switch_Db  out  1  debounced switch level
// -----------------------------------------------------------------------------
module blink_rate_select #(
  parameter int unsigned g_DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic [3:0] i_Blink,
  output logic       o_LED,
  output logic [2:0] o_Sel,
  output logic       o_Switch_Db
);

  localparam logic [2:0] S_10HZ = 3'd0;
  localparam logic [2:0] S_5HZ  = 3'd1;
  localparam logic [2:0] S_2HZ  = 3'd2;
  localparam logic [2:0] S_1HZ  = 3'd3;
  localparam logic [2:0] S_OFF  = 3'd4;

  // Terminal count of the debounce counter.
  localparam logic [31:0] c_CNT_LAST = 32'(g_DEBOUNCE_LIMIT - 1);

  logic        r_Meta;
  logic        r_Sync;
  logic [31:0] r_Cnt;
  logic        r_Db;
  logic        w_Accept;
  logic        w_Press;
  logic [2:0]  r_Sel;
  logic [2:0]  w_Sel_Next;
  logic        r_LED;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. The first flop may go metastable, so nothing but the
  // second flop looks at it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Meta <= 1'b0;
      r_Sync <= 1'b0;
    end else begin
      r_Meta <= i_Switch_1;
      r_Sync <= r_Meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer. The counter only runs while the synchronized input disagrees
  // with the accepted level; one cycle of agreement restarts it. It is cleared
  // when it reaches the terminal count, so it can never wrap.
  // ---------------------------------------------------------------------------
  assign w_Accept = (r_Sync != r_Db) && (r_Cnt == c_CNT_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Cnt <= '0;
      r_Db  <= 1'b0;
    end else if (r_Sync == r_Db) begin
      r_Cnt <= '0;
    end else if (w_Accept) begin
      r_Db  <= r_Sync;
      r_Cnt <= '0;
    end else begin
      r_Cnt <= r_Cnt + 32'd1;
    end
  end

  // A press is the cycle in which the debounced level is about to go 0 -> 1,
  // so the selector advances on the same edge that r_Db rises.
  assign w_Press = w_Accept && r_Sync;

  // ---------------------------------------------------------------------------
  // Selector FSM.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_Sel_Next = r_Sel;
    if (w_Press) begin
      case (r_Sel)
        S_10HZ:  w_Sel_Next = S_5HZ;
        S_5HZ:   w_Sel_Next = S_2HZ;
        S_2HZ:   w_Sel_Next = S_1HZ;
        S_1HZ:   w_Sel_Next = S_OFF;
        S_OFF:   w_Sel_Next = S_10HZ;
        default: w_Sel_Next = S_10HZ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sel <= S_10HZ;
    end else begin
      r_Sel <= w_Sel_Next;
    end
  end

  // ---------------------------------------------------------------------------
  // LED register. Indexed by the registered selection, so a new selection
  // reaches the LED one edge after o_Sel changes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_LED <= 1'b0;
    end else if (r_Sel == S_OFF) begin
      r_LED <= 1'b0;
    end else begin
      r_LED <= i_Blink[r_Sel[1:0]];
    end
  end

  assign o_LED       = r_LED;
  assign o_Sel       = r_Sel;
  assign o_Switch_Db = r_Db;

endmodule
